mem_request_responder: RTL and testbench
========================================

Name: mem_request_responder

Overview:
- Memory-side responder to the CPU request unit. Accepts instruction-fetch and data read/write requests.
- Arbitrates them onto one single-ported RAM handshake and returns one-cycle ihit/dhit pulses with load data.
- Sits between the datapath's request unit and the RAM model or cache.
- Data requests have priority over instruction fetch.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, word width in bits

Ports:
CLK  in  1  clock; all state updates on the rising edge
RST  in  1  synchronous, active-high reset
iREN  in  1  instruction fetch request (level)
iaddr  in  ADDR_W  fetch address
dREN  in  1  data read request (level)
dWEN  in  1  data write request (level)
daddr  in  ADDR_W  data address
dstore  in  DATA_W  store data
ihit  out  1  one-cycle pulse: fetch complete, iload valid
dhit  out  1  one-cycle pulse: data access complete, dload valid for reads
iload  out  DATA_W  fetched instruction
dload  out  DATA_W  loaded data
ram_ren  out  1  RAM read strobe
ram_wen  out  1  RAM write strobe
ram_addr  out  ADDR_W  RAM address, word aligned
ram_store  out  DATA_W  RAM write data
ram_load  in  DATA_W  RAM read data
ram_ready  in  1  RAM access complete this cycle

Behaviour:
- Clock and reset: one clock CLK. Reset RST is synchronous and active-high.
- Reset values: state IDLE; ihit=0, dhit=0; iload=0, dload=0; ram_ren=0, ram_wen=0; ram_addr=0, ram_store=0. All outputs are registered.
- FSM states: IDLE, IBUSY, DBUSY, RESP.
- IDLE:
  - If dWEN|dREN: latch daddr, dstore and the op type, then go to DBUSY. dWEN wins if both are high; the access is a write.
  - Else if iREN: latch iaddr, then go to IBUSY.
  - Else: stay in IDLE.
  - ram_ready is ignored in IDLE.
- Address alignment: the latched address has [1:0] forced to 0 before it drives ram_addr.
- IBUSY / DBUSY:
  - ram_ren or ram_wen is asserted from the first cycle in the state (registered on the IDLE->BUSY edge).
  - ram_addr and ram_store are held stable.
  - Requester inputs are not re-sampled; changes while busy are ignored.
  - When ram_ready=1: capture ram_load into iload (IBUSY) or dload (DBUSY, read only), drop the strobes on the same edge, and go to RESP.
- Write completion: dload is unchanged on a write.
- RESP:
  - ihit=1 or dhit=1 for exactly this one cycle, then return to IDLE.
  - Minimum latency, request to hit: 3 cycles (IDLE sample, BUSY with ram_ready=1, RESP).
  - Latency with N wait cycles: 3+N.
- Hit handshake: the requester must drop or replace its request at the edge that ends RESP.
  - A request still high in the following IDLE is treated as a new access.
- Arbitration: data requests have priority. A pending iREN is served at the first IDLE with no data request.
- Data registers: iload/dload hold their last value until overwritten.
- Reset mid-access: any state returns to IDLE with strobes and hits cleared the next edge. The in-flight access is abandoned and no hit is issued.
- Never asserted: ihit and dhit together; ram_ren and ram_wen together.

Optional Feature:
MEM_PERF_CNT_EN:
- Defined: adds outputs icount, dcount and stallcount (32 bits each, reset 0).
  - icount increments on each ihit.
  - dcount increments on each dhit.
  - stallcount increments on each IBUSY/DBUSY cycle with ram_ready=0.
  - All wrap modulo 2^32.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset: RST=1 for 2 cycles with iREN=1 -> all outputs 0, state IDLE, no ram strobe. After release, ram_ren rises 1 cycle later.
- Fetch, zero-wait: iREN=1, iaddr=0x0000_0104, ram_ready=1 in the first busy cycle, ram_load=0x2001_0005 -> ram_addr=0x104, ihit pulses on cycle 3, iload=0x2001_0005.
- Unaligned write with 2 wait cycles: dWEN=1, daddr=0x0000_0203, dstore=0xDEAD_BEEF -> ram_wen=1, ram_addr=0x200, ram_store=0xDEAD_BEEF, dhit pulses on cycle 5, dload unchanged.
- Priority: iREN=1 and dREN=1 in the same IDLE cycle, daddr=0x80 -> data access first with dhit. Then, iREN still high, fetch follows with ihit; never both hits in one cycle.
- dREN=dWEN=1 -> write performed (ram_wen=1, ram_ren=0).
- Reset in DBUSY after 1 wait cycle -> next cycle IDLE, ram_wen=0, no dhit ever issued for that access.
- With MEM_PERF_CNT_EN defined: 2 fetches with 1 wait cycle each plus 1 read with 0 wait cycles -> icount=2, dcount=1, stallcount=2.

Source files
------------

// File: rtl/mem_request_responder_if.sv
// Request-unit and RAM handshake bundle for mem_request_responder.
// slave = responder view, master = requester/RAM-model view.
interface mem_request_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              ihit;
  logic              dhit;
  logic [DATA_W-1:0] iload;
  logic [DATA_W-1:0] dload;
  logic              ram_ren;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_store;
  logic [DATA_W-1:0] ram_load;
  logic              ram_ready;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ready,
    output ihit, dhit, iload, dload, ram_ren, ram_wen, ram_addr, ram_store
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ready,
    input  ihit, dhit, iload, dload, ram_ren, ram_wen, ram_addr, ram_store
  );
endinterface

// File: rtl/mem_request_responder.sv
// Arbitrates fetch and data requests onto one RAM port; data wins. Returns one-cycle hits.
// Optional macro MEM_PERF_CNT_EN adds icount/dcount/stallcount outputs.
module mem_request_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  mem_request_responder_if.slave       bus,
  output logic [1:0]                   state_dbg
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [31:0]                  icount,
  output logic [31:0]                  dcount,
  output logic [31:0]                  stallcount
`endif
);
  // Handshake: a request level is sampled only in IDLE; once busy, requester
  // inputs are ignored until the hit pulse (RESP). The RAM side holds
  // ren/wen/addr/store stable until ram_ready=1 completes the access.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t            state_q, state_n;
  logic              ihit_q, ihit_n;
  logic              dhit_q, dhit_n;
  logic              ren_q, ren_n;
  logic              wen_q, wen_n;
  logic              is_wr_q, is_wr_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] store_q, store_n;
  logic [DATA_W-1:0] iload_q, iload_n;
  logic [DATA_W-1:0] dload_q, dload_n;

  always_comb begin
    state_n = state_q;
    ihit_n  = 1'b0;
    dhit_n  = 1'b0;
    ren_n   = ren_q;
    wen_n   = wen_q;
    is_wr_n = is_wr_q;
    addr_n  = addr_q;
    store_n = store_q;
    iload_n = iload_q;
    dload_n = dload_q;
    case (state_q)
      IDLE: begin
        if (bus.dWEN || bus.dREN) begin
          addr_n  = bus.daddr & ALIGN_MASK;
          store_n = bus.dstore;
          is_wr_n = bus.dWEN;
          wen_n   = bus.dWEN;
          ren_n   = ~bus.dWEN;
          state_n = DBUSY;
        end else if (bus.iREN) begin
          addr_n  = bus.iaddr & ALIGN_MASK;
          ren_n   = 1'b1;
          wen_n   = 1'b0;
          state_n = IBUSY;
        end
      end
      IBUSY: begin
        if (bus.ram_ready) begin
          iload_n = bus.ram_load;
          ren_n   = 1'b0;
          wen_n   = 1'b0;
          ihit_n  = 1'b1;
          state_n = RESP;
        end
      end
      DBUSY: begin
        if (bus.ram_ready) begin
          if (!is_wr_q) dload_n = bus.ram_load;
          ren_n   = 1'b0;
          wen_n   = 1'b0;
          dhit_n  = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        ren_n   = 1'b0;
        wen_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ihit_q  <= 1'b0;
      dhit_q  <= 1'b0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
      iload_q <= '0;
      dload_q <= '0;
    end else begin
      state_q <= state_n;
      ihit_q  <= ihit_n;
      dhit_q  <= dhit_n;
      ren_q   <= ren_n;
      wen_q   <= wen_n;
      is_wr_q <= is_wr_n;
      addr_q  <= addr_n;
      store_q <= store_n;
      iload_q <= iload_n;
      dload_q <= dload_n;
    end
  end

  assign bus.ihit      = ihit_q;
  assign bus.dhit      = dhit_q;
  assign bus.iload     = iload_q;
  assign bus.dload     = dload_q;
  assign bus.ram_ren   = ren_q;
  assign bus.ram_wen   = wen_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_store = store_q;
  assign state_dbg     = state_q;

`ifdef MEM_PERF_CNT_EN
  // A stall is any busy cycle in which the RAM has not yet completed.
  always_ff @(posedge CLK) begin
    if (RST) begin
      icount     <= '0;
      dcount     <= '0;
      stallcount <= '0;
    end else begin
      if (ihit_q) icount <= icount + 32'd1;
      if (dhit_q) dcount <= dcount + 32'd1;
      if ((state_q == IBUSY || state_q == DBUSY) && !bus.ram_ready)
        stallcount <= stallcount + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_request_responder.sv
// Bench for mem_request_responder: vector table plus random traffic, hits scored against an expected queue.
module tb_mem_request_responder;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] state_dbg;
`ifdef MEM_PERF_CNT_EN
  logic [31:0] icount, dcount, stallcount;
`endif

  mem_request_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_request_responder #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .state_dbg (state_dbg)
`ifdef MEM_PERF_CNT_EN
    ,
    .icount    (icount),
    .dcount    (dcount),
    .stallcount(stallcount)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  op;       // 0 fetch, 1 read, 2 write, 3 read+write
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] load;
    int          waits;
    logic [31:0] exp_addr;
    logic        exp_ren;
    logic        exp_wen;
  } vec_t;

  logic [31:0] exp_q[$];
  logic        kind_q[$];   // 0 = expect ihit, 1 = expect dhit
  logic [31:0] dload_m = '0;
  int          errors = 0;
  int          checks = 0;
  vec_t        vecs[6];

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      checks++;
      if ((bus.ihit && bus.dhit) || (bus.ram_ren && bus.ram_wen)) begin
        errors++;
        $display("FAIL exclusive: ihit=%0b dhit=%0b ren=%0b wen=%0b",
                 bus.ihit, bus.dhit, bus.ram_ren, bus.ram_wen);
      end
    end
  end

  // Called in the first busy cycle; completes the access and scores the hit.
  task automatic serve(input int waits, input logic [31:0] load, input logic [31:0] exp_addr,
                       input logic exp_ren, input logic exp_wen);
    int n;
    logic [31:0] e;
    logic k;
    for (int w = 0; w < waits; w++) begin
      bus.ram_ready = 1'b0;
      bus.ram_load  = $urandom;
      tick();
      chk("hold_ren", {31'd0, bus.ram_ren}, {31'd0, exp_ren});
      chk("hold_addr", bus.ram_addr, exp_addr);
    end
    bus.ram_ready = 1'b1;
    bus.ram_load  = load;
    tick();
    bus.ram_ready = 1'b0;
    bus.ram_load  = $urandom;
    n = 0;
    while (!(bus.ihit || bus.dhit) && n < 8) begin
      tick();
      n++;
    end
    chk("hit_latency", n, 0);
    if (bus.ihit || bus.dhit) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_hit", 1, 0);
      end else begin
        e = exp_q.pop_front();
        k = kind_q.pop_front();
        chk("hit_kind", {30'd0, bus.dhit, bus.ihit}, k ? 32'd2 : 32'd1);
        chk(k ? "dload" : "iload", k ? bus.dload : bus.iload, e);
      end
    end
    chk("strobes_off", {30'd0, bus.ram_ren, bus.ram_wen}, 32'd0);
    tick();
    chk("hit_pulse_end", {30'd0, bus.ihit, bus.dhit}, 32'd0);
    chk("back_idle", {30'd0, state_dbg}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    case (v.op)
      2'd0: begin bus.iREN = 1'b1; bus.iaddr = v.addr; end
      2'd1: begin bus.dREN = 1'b1; bus.daddr = v.addr; end
      default: begin
        bus.dWEN = 1'b1; bus.dREN = (v.op == 2'd3);
        bus.daddr = v.addr; bus.dstore = v.store;
      end
    endcase
    if (v.op == 2'd0) begin
      exp_q.push_back(v.load); kind_q.push_back(1'b0);
    end else if (v.op == 2'd1) begin
      dload_m = v.load;
      exp_q.push_back(v.load); kind_q.push_back(1'b1);
    end else begin
      exp_q.push_back(dload_m); kind_q.push_back(1'b1);
    end
    tick();
    // Change requester inputs while busy; they must be ignored.
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.iaddr = $urandom; bus.daddr = $urandom; bus.dstore = $urandom;
    chk("ram_ren", {31'd0, bus.ram_ren}, {31'd0, v.exp_ren});
    chk("ram_wen", {31'd0, bus.ram_wen}, {31'd0, v.exp_wen});
    chk("ram_addr", bus.ram_addr, v.exp_addr);
    if (v.exp_wen) chk("ram_store", bus.ram_store, v.store);
    serve(v.waits, v.load, v.exp_addr, v.exp_ren, v.exp_wen);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t r;
    bus.iREN = 1'b1; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.daddr = '0; bus.dstore = '0; bus.ram_load = '0; bus.ram_ready = 1'b0;

    vecs[0] = '{2'd0, 32'h0000_0104, 32'h0,         32'h2001_0005, 0, 32'h0000_0104, 1'b1, 1'b0};
    vecs[1] = '{2'd2, 32'h0000_0203, 32'hDEAD_BEEF, 32'h7777_7777, 2, 32'h0000_0200, 1'b0, 1'b1};
    vecs[2] = '{2'd1, 32'h0000_0080, 32'h0,         32'h1122_3344, 1, 32'h0000_0080, 1'b1, 1'b0};
    vecs[3] = '{2'd3, 32'h0000_0030, 32'hCAFE_F00D, 32'h9999_0000, 0, 32'h0000_0030, 1'b0, 1'b1};
    vecs[4] = '{2'd0, 32'h0000_0107, 32'h0,         32'hA5A5_5A5A, 3, 32'h0000_0104, 1'b1, 1'b0};
    vecs[5] = '{2'd1, 32'hFFFF_FFFE, 32'h0,         32'h0BAD_F00D, 0, 32'hFFFF_FFFC, 1'b1, 1'b0};

    // Reset held two cycles with iREN high
    tick(); tick();
    chk("rst_state", {30'd0, state_dbg}, 32'd0);
    chk("rst_strobes", {30'd0, bus.ram_ren, bus.ram_wen}, 32'd0);
    chk("rst_hits", {30'd0, bus.ihit, bus.dhit}, 32'd0);
    chk("rst_loads", bus.iload | bus.dload, 32'd0);
    chk("rst_addr_store", bus.ram_addr | bus.ram_store, 32'd0);
    RST = 1'b0;
    exp_q.push_back(32'h0000_0001); kind_q.push_back(1'b0);
    tick();
    bus.iREN = 1'b0;
    chk("post_rst_ren", {31'd0, bus.ram_ren}, 32'd1);
    chk("post_rst_addr", bus.ram_addr, 32'd0);
    serve(0, 32'h0000_0001, 32'd0, 1'b1, 1'b0);

    foreach (vecs[i]) run_vec(vecs[i]);

    for (int i = 0; i < 6; i++) begin
      r.op = 2'($urandom_range(0, 3));
      r.addr = $urandom; r.store = $urandom; r.load = $urandom;
      r.waits = $urandom_range(0, 3);
      r.exp_addr = r.addr & 32'hFFFF_FFFC;
      r.exp_ren = (r.op < 2'd2);
      r.exp_wen = (r.op >= 2'd2);
      run_vec(r);
    end

    // Priority: data first, fetch follows while iREN stays high
    bus.iREN = 1'b1; bus.iaddr = 32'h0000_0300;
    bus.dREN = 1'b1; bus.daddr = 32'h0000_0080;
    dload_m = 32'h55AA_55AA;
    exp_q.push_back(32'h55AA_55AA); kind_q.push_back(1'b1);
    exp_q.push_back(32'h1234_5678); kind_q.push_back(1'b0);
    tick();
    chk("prio_addr", bus.ram_addr, 32'h0000_0080);
    bus.ram_ready = 1'b1; bus.ram_load = 32'h55AA_55AA;
    tick();
    bus.ram_ready = 1'b0;
    bus.dREN = 1'b0;
    chk("prio_dhit", {30'd0, bus.ihit, bus.dhit}, 32'd1);
    chk("prio_dload", bus.dload, exp_q.pop_front());
    void'(kind_q.pop_front());
    tick();
    chk("prio_idle", {30'd0, state_dbg}, 32'd0);
    tick();
    bus.iREN = 1'b0;
    chk("prio_fetch_addr", bus.ram_addr, 32'h0000_0300);
    serve(0, 32'h1234_5678, 32'h0000_0300, 1'b1, 1'b0);

    // Reset in DBUSY after one wait cycle: access abandoned, no dhit
    bus.dWEN = 1'b1; bus.daddr = 32'h0000_0040; bus.dstore = 32'h0F0F_0F0F;
    tick();
    bus.dWEN = 1'b0;
    bus.ram_ready = 1'b0;
    tick();
    chk("mid_busy_wen", {31'd0, bus.ram_wen}, 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    dload_m = '0;
    chk("mid_rst_state", {30'd0, state_dbg}, 32'd0);
    chk("mid_rst_wen", {31'd0, bus.ram_wen}, 32'd0);
    chk("mid_rst_loads", bus.iload | bus.dload, 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus.ram_ready = 1'b1;
      tick();
      chk("no_abandoned_hit", {30'd0, bus.ihit, bus.dhit}, 32'd0);
    end
    bus.ram_ready = 1'b0;

`ifdef MEM_PERF_CNT_EN
    r = '{2'd0, 32'h0000_0010, 32'h0, 32'h0000_00AA, 1, 32'h0000_0010, 1'b1, 1'b0};
    run_vec(r);
    r = '{2'd0, 32'h0000_0014, 32'h0, 32'h0000_00BB, 1, 32'h0000_0014, 1'b1, 1'b0};
    run_vec(r);
    r = '{2'd1, 32'h0000_0020, 32'h0, 32'h0000_00CC, 0, 32'h0000_0020, 1'b1, 1'b0};
    run_vec(r);
    chk("icount", icount, 32'd2);
    chk("dcount", dcount, 32'd1);
    chk("stallcount", stallcount, 32'd2);
`endif

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
